// File: rtl/pwm_seq_pkg.sv
// Shared constants for the PWM step sequencer: register map, control bits,
// sequencer state encoding and the effective-length helper.
package pwm_seq_pkg;

    localparam logic [6:0] REG_OUT_7_0  = 7'h00;
    localparam logic [6:0] REG_OUT_15_8 = 7'h01;
    localparam logic [6:0] REG_PWM_7_0  = 7'h02;
    localparam logic [6:0] REG_PWM_15_8 = 7'h03;
    localparam logic [6:0] REG_PWM_DUTY = 7'h04;
    localparam logic [6:0] SEQ_CTRL     = 7'h10;
    localparam logic [6:0] SEQ_LEN      = 7'h11;
    localparam logic [6:0] SEQ_DWELL    = 7'h12;
    localparam logic [6:0] TABLE_BASE   = 7'h20;

    localparam int CTRL_RUN_BIT  = 0;
    localparam int CTRL_LOOP_BIT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2
    } seq_state_t;

    // Number of table steps actually walked: SEQ_LEN clamped into 1..depth.
    function automatic logic [4:0] eff_len(input logic [7:0] len, input int depth);
        if (len == 8'd0) begin
            return 5'd1;
        end
        if (int'(len) > depth) begin
            return 5'(depth);
        end
        return len[4:0];
    endfunction

endpackage

// File: rtl/pwm_seq_timer.sv
// Dwell timer: PRESCALE-cycle prescaler feeding a tick down-counter.
// expire is high in the last cycle of a ticks*PRESCALE-cycle interval.
module pwm_seq_timer
    import pwm_seq_pkg::*;
#(
    parameter int PRESCALE = 3000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       clear,
    input  logic [7:0] ticks,
    output logic       expire
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [7:0]    tick_q;
    logic          active_q;

    assign expire = active_q && (pre_q == '0) && (tick_q == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            tick_q   <= 8'd0;
            active_q <= 1'b0;
        end else if (clear) begin
            active_q <= 1'b0;
        end else if (load) begin
            // ticks is never 0 here; the caller substitutes 1 for a zero DWELL.
            pre_q    <= PRE_MAX;
            tick_q   <= ticks - 8'd1;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (expire) begin
                active_q <= 1'b0;
            end else if (pre_q == '0) begin
                pre_q  <= PRE_MAX;
                tick_q <= tick_q - 8'd1;
            end else begin
                pre_q <= pre_q - PW'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_step_sequencer.sv
// PWM register bank plus duty-cycle step sequencer (IDLE/LOAD/DWELL).
// Loop mode is compiled in only when PWM_SEQ_LOOP_EN is defined.
module pwm_step_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PRESCALE = 3000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [6:0]               wr_addr,
    input  logic [7:0]               wr_data,
    output logic [7:0]               en_reg_out_7_0,
    output logic [7:0]               en_reg_out_15_8,
    output logic [7:0]               en_reg_pwm_7_0,
    output logic [7:0]               en_reg_pwm_15_8,
    output logic [7:0]               pwm_duty_cycle,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     seq_done
);

    localparam int IW = $clog2(DEPTH);

    logic [7:0]    out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;
    logic [7:0]    len_q, dwell_q;
    logic [7:0]    tbl_q [DEPTH];
    seq_state_t    state_q;
    logic [IW-1:0] idx_q;
    logic          loop_q, done_q;

    logic          wr_ctrl, start_req, stop_req, host_duty, tbl_hit;
    logic          loop_d, tmr_load, tmr_expire;
    logic [IW-1:0] tbl_widx, last_idx_d;
    logic [7:0]    load_val_d, dwell_eff_d;

    assign wr_ctrl   = wr_valid && (wr_addr == SEQ_CTRL);
    assign start_req = wr_ctrl && wr_data[CTRL_RUN_BIT];
    assign stop_req  = wr_ctrl && !wr_data[CTRL_RUN_BIT];
    assign host_duty = wr_valid && (wr_addr == REG_PWM_DUTY);
    assign tbl_hit   = wr_valid && (wr_addr >= TABLE_BASE) &&
                       (wr_addr < (TABLE_BASE + 7'(DEPTH)));
    assign tbl_widx  = IW'(wr_addr - TABLE_BASE);

`ifdef PWM_SEQ_LOOP_EN
    assign loop_d = wr_data[CTRL_LOOP_BIT];
`else
    assign loop_d = 1'b0;
`endif

    // A table write landing on the entry being loaded is forwarded straight to duty.
    assign load_val_d  = (tbl_hit && (tbl_widx == idx_q)) ? wr_data : tbl_q[idx_q];
    assign last_idx_d  = IW'(eff_len(len_q, DEPTH) - 5'd1);
    assign dwell_eff_d = (dwell_q == 8'd0) ? 8'd1 : dwell_q;
    assign tmr_load    = (state_q == LOAD) && !stop_req;

    pwm_seq_timer #(
        .PRESCALE(PRESCALE)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .clear (stop_req),
        .ticks (dwell_eff_d),
        .expire(tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_lo_q <= 8'd0;
            out_hi_q <= 8'd0;
            pwm_lo_q <= 8'd0;
            pwm_hi_q <= 8'd0;
            len_q    <= 8'd1;
            dwell_q  <= 8'd1;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= 8'd0;
            end
        end else if (wr_valid) begin
            case (wr_addr)
                REG_OUT_7_0:  out_lo_q <= wr_data;
                REG_OUT_15_8: out_hi_q <= wr_data;
                REG_PWM_7_0:  pwm_lo_q <= wr_data;
                REG_PWM_15_8: pwm_hi_q <= wr_data;
                SEQ_LEN:      len_q    <= wr_data;
                SEQ_DWELL:    dwell_q  <= wr_data;
                default: ;
            endcase
            if (tbl_hit) begin
                tbl_q[tbl_widx] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            duty_q  <= 8'd0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wr_ctrl) begin
                loop_q <= loop_d;
            end
            // Host duty writes always land; in LOAD they pre-empt the table value.
            if (host_duty) begin
                duty_q <= wr_data;
            end
            if (stop_req) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_req) begin
                            idx_q   <= '0;
                            state_q <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (!host_duty) begin
                            duty_q <= load_val_d;
                        end
                        state_q <= DWELL;
                    end
                    DWELL: begin
                        if (tmr_expire) begin
                            if (idx_q < last_idx_d) begin
                                idx_q   <= idx_q + IW'(1);
                                state_q <= LOAD;
                            end else if (loop_q) begin
                                idx_q   <= '0;
                                state_q <= LOAD;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign busy            = (state_q != IDLE);
    assign step_idx        = idx_q;
    assign seq_done        = done_q;

endmodule

// File: tb/tb_pwm_step_sequencer.sv
// Scoreboard bench for pwm_step_sequencer with PRESCALE = 4, DEPTH = 8.
// Expectations are queued per cycle by the driver and compared at negedge.
module tb_pwm_step_sequencer;

    localparam int DEPTH    = 8;
    localparam int PRESCALE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [6:0] wr_addr = 7'd0;
    logic [7:0] wr_data = 8'd0;
    logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
    logic       busy, seq_done;
    logic [2:0] step_idx;

    pwm_step_sequencer #(
        .DEPTH   (DEPTH),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .en_reg_out_7_0 (out_lo),
        .en_reg_out_15_8(out_hi),
        .en_reg_pwm_7_0 (pwm_lo),
        .en_reg_pwm_15_8(pwm_hi),
        .pwm_duty_cycle (duty),
        .busy           (busy),
        .step_idx       (step_idx),
        .seq_done       (seq_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int S_DUTY = 0, S_BUSY = 1, S_DONE = 2, S_IDX = 3;
    localparam int S_OLO = 4, S_OHI = 5, S_PLO = 6, S_PHI = 7;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t       sb_q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] tbl_m [DEPTH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            S_DUTY:  return {24'd0, duty};
            S_BUSY:  return {31'd0, busy};
            S_DONE:  return {31'd0, seq_done};
            S_IDX:   return {29'd0, step_idx};
            S_OLO:   return {24'd0, out_lo};
            S_OHI:   return {24'd0, out_hi};
            S_PLO:   return {24'd0, pwm_lo};
            default: return {24'd0, pwm_hi};
        endcase
    endfunction

    // Keep the queue ordered by cycle so the monitor only ever looks at the head.
    task automatic ex(input int c, input int sel, input logic [31:0] v, input string tag);
        exp_t e;
        int   pos;
        e.cyc = c; e.sel = sel; e.exp = v; e.tag = tag;
        pos = sb_q.size();
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].cyc > c) begin
                pos = i;
                break;
            end
        end
        sb_q.insert(pos, e);
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            check_val(e.tag, sample(e.sel), e.exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        if (a >= 7'h20 && a < 7'h28) tbl_m[int'(a) - 32] = d;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int T, S, R;
        logic [7:0] dstop;
        for (int i = 0; i < DEPTH; i++) tbl_m[i] = 8'd0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        ex(cyc, S_DUTY, 0, "rst_duty");
        ex(cyc, S_BUSY, 0, "rst_busy");
        ex(cyc, S_DONE, 0, "rst_done");
        ex(cyc, S_IDX,  0, "rst_idx");
        ex(cyc, S_OLO,  0, "rst_out_lo");
        ex(cyc, S_PHI,  0, "rst_pwm_hi");
        tick();

        // Plain register writes and ignored addresses
        T = cyc;
        ex(T + 1, S_OLO,  8'hA5, "wr_out_lo");
        ex(T + 2, S_DUTY, 8'h80, "wr_duty");
        ex(T + 3, S_OHI,  8'h3C, "wr_out_hi");
        ex(T + 4, S_PLO,  8'hC3, "wr_pwm_lo");
        ex(T + 5, S_PHI,  8'h5A, "wr_pwm_hi");
        ex(T + 7, S_OLO,  8'hA5, "ign_out_lo");
        ex(T + 7, S_OHI,  8'h3C, "ign_out_hi");
        ex(T + 7, S_PLO,  8'hC3, "ign_pwm_lo");
        ex(T + 7, S_PHI,  8'h5A, "ign_pwm_hi");
        ex(T + 7, S_DUTY, 8'h80, "ign_duty");
        ex(T + 7, S_BUSY, 0,     "ign_busy");
        wr(7'h00, 8'hA5);
        wr(7'h04, 8'h80);
        wr(7'h01, 8'h3C);
        wr(7'h02, 8'hC3);
        wr(7'h03, 8'h5A);
        wr(7'h7F, 8'hFF);
        wr(7'h13, 8'hEE);
        wait_until(T + 9);

        // One-shot run over three steps, dwell 2 ticks
        wr(7'h20, 8'h10);
        wr(7'h21, 8'h20);
        wr(7'h22, 8'h30);
        wr(7'h11, 8'd3);
        wr(7'h12, 8'd2);
        T = cyc;
        ex(T + 1,  S_DUTY, 8'h80, "os_load_hold");
        ex(T + 1,  S_BUSY, 1,     "os_busy_load");
        ex(T + 2,  S_DUTY, 8'h10, "os_step0");
        ex(T + 2,  S_IDX,  0,     "os_idx0");
        ex(T + 10, S_DUTY, 8'h10, "os_step0_end");
        ex(T + 11, S_DUTY, 8'h20, "os_step1");
        ex(T + 11, S_IDX,  1,     "os_idx1");
        ex(T + 19, S_DUTY, 8'h20, "os_step1_end");
        ex(T + 19, S_DONE, 0,     "os_no_done");
        ex(T + 20, S_DUTY, 8'h30, "os_step2");
        ex(T + 20, S_IDX,  2,     "os_idx2");
        ex(T + 27, S_BUSY, 1,     "os_busy_last");
        ex(T + 27, S_DONE, 0,     "os_done_early");
        ex(T + 28, S_DONE, 1,     "os_done");
        ex(T + 28, S_BUSY, 0,     "os_busy_done");
        ex(T + 29, S_DONE, 0,     "os_done_width");
        ex(T + 29, S_DUTY, 8'h30, "os_duty_hold");
        wr(7'h10, 8'h01);
        wait_until(T + 31);

        // Loop-mode run, then stop mid-dwell
        T = cyc;
        ex(T + 20, S_DUTY, 8'h30, "lp_step2");
`ifdef PWM_SEQ_LOOP_EN
        ex(T + 28, S_BUSY, 1,     "lp_busy_wrap");
        ex(T + 28, S_DONE, 0,     "lp_no_done");
        ex(T + 29, S_DUTY, 8'h10, "lp_wrap_step0");
        ex(T + 29, S_IDX,  0,     "lp_wrap_idx");
        ex(T + 38, S_DUTY, 8'h20, "lp_wrap_step1");
        dstop = 8'h20;
`else
        ex(T + 28, S_DONE, 1,     "lp_off_done");
        ex(T + 28, S_BUSY, 0,     "lp_off_busy");
        ex(T + 29, S_DUTY, 8'h30, "lp_off_hold");
        ex(T + 35, S_IDX,  2,     "lp_off_idx");
        dstop = 8'h30;
`endif
        wr(7'h10, 8'h03);
        wait_until(T + 40);
        S = cyc;
        ex(S + 1,  S_BUSY, 0,     "stop_busy");
        ex(S + 1,  S_DUTY, dstop, "stop_duty");
        ex(S + 12, S_DUTY, dstop, "stop_duty_hold");
        ex(S + 12, S_IDX,  (dstop == 8'h20) ? 1 : 2, "stop_idx_hold");
        for (int k = 1; k <= 12; k++) ex(S + k, S_DONE, 0, "stop_no_done");
        wr(7'h10, 8'h00);
        wait_until(S + 14);

        // Zero LEN and DWELL: single step of one tick
        wr(7'h11, 8'd0);
        wr(7'h12, 8'd0);
        T = cyc;
        ex(T + 2, S_DUTY, tbl_m[0], "len0_step0");
        ex(T + 5, S_BUSY, 1,        "len0_busy");
        ex(T + 5, S_DONE, 0,        "len0_done_early");
        ex(T + 6, S_DONE, 1,        "len0_done");
        ex(T + 6, S_BUSY, 0,        "len0_idle");
        ex(T + 7, S_DONE, 0,        "len0_done_width");
        wr(7'h10, 8'h01);
        wait_until(T + 8);

        // LEN above DEPTH clamps to the full table; 0x28 is outside the table
        wr(7'h28, 8'hEE);
        wr(7'h23, 8'h44);
        wr(7'h24, 8'h55);
        wr(7'h25, 8'h66);
        wr(7'h26, 8'h77);
        wr(7'h27, 8'h88);
        wr(7'h11, 8'd20);
        T = cyc;
        for (int k = 0; k < DEPTH; k++) begin
            ex(T + 2 + 5 * k, S_DUTY, tbl_m[k], "clamp_duty");
            ex(T + 2 + 5 * k, S_IDX,  k,        "clamp_idx");
        end
        ex(T + 40, S_BUSY, 1, "clamp_busy_last");
        ex(T + 40, S_DONE, 0, "clamp_done_early");
        ex(T + 41, S_DONE, 1, "clamp_done");
        ex(T + 41, S_BUSY, 0, "clamp_idle");
        wr(7'h10, 8'h01);
        wait_until(T + 43);

        // Host duty write in LOAD and in DWELL; table write on the loading entry
        wr(7'h11, 8'd3);
        wr(7'h12, 8'd1);
        T = cyc;
        ex(T + 2,  S_DUTY, 8'hFF,    "host_load_win");
        ex(T + 5,  S_DUTY, 8'hFF,    "host_load_hold");
        ex(T + 7,  S_DUTY, tbl_m[1], "host_next_load");
        ex(T + 9,  S_DUTY, 8'h5A,    "host_dwell_wr");
        ex(T + 11, S_DUTY, 8'h5A,    "host_dwell_hold");
        ex(T + 12, S_DUTY, 8'h3C,    "tbl_bypass");
        ex(T + 16, S_DONE, 1,        "host_done");
        wr(7'h10, 8'h01);
        wr(7'h04, 8'hFF);
        wait_until(T + 8);
        wr(7'h04, 8'h5A);
        wait_until(T + 11);
        wr(7'h22, 8'h3C);
        wait_until(T + 18);

        // Asynchronous reset in the middle of step 1's dwell
        wr(7'h12, 8'd2);
        T = cyc;
        R = T + 14;
        ex(R - 1, S_IDX,  1, "prerst_idx");
        ex(R - 1, S_BUSY, 1, "prerst_busy");
        ex(R, S_BUSY, 0, "arst_busy");
        ex(R, S_IDX,  0, "arst_idx");
        ex(R, S_DUTY, 0, "arst_duty");
        ex(R, S_OLO,  0, "arst_out_lo");
        ex(R, S_DONE, 0, "arst_done");
        for (int k = 3; k <= 20; k++) ex(R + k, S_DONE, 0, "postrst_no_done");
        ex(R + 20, S_BUSY, 0, "postrst_idle");
        wr(7'h10, 8'h01);
        wait_until(R);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) tbl_m[i] = 8'd0;
        wait_until(R + 22);

        // Post-reset run uses reset LEN = 1, DWELL = 1 and a cleared table
        T = cyc;
        ex(T + 2, S_DUTY, tbl_m[0], "rstval_duty");
        ex(T + 5, S_BUSY, 1,        "rstval_busy");
        ex(T + 6, S_DONE, 1,        "rstval_done");
        ex(T + 6, S_BUSY, 0,        "rstval_idle");
        wr(7'h10, 8'h01);
        wait_until(T + 8);

        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_val(e.tag, sample(e.sel), e.exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pwm_step_sequencer.md
# pwm_step_sequencer

Register-bank owner and duty-cycle scheduler for the PWM peripheral. It accepts decoded single-cycle register writes from the SPI peripheral and holds the five PWM configuration registers plus a small duty-cycle step table. When started, an internal sequencer walks the table and updates `pwm_duty_cycle` at a programmable dwell interval, in one-shot or loop mode. It sits between the SPI peripheral and the PWM peripheral.

## Interface
- `DEPTH`, 8: step-table entries; power of two, 2..16.
- `PRESCALE`, 3000: clk cycles per dwell tick; ≥ 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `wr_valid`  in  1  one-cycle write strobe from the SPI peripheral.
- `wr_addr`  in  7  write address.
- `wr_data`  in  8  write data.
- `en_reg_out_7_0`, `en_reg_out_15_8`, `en_reg_pwm_7_0`, `en_reg_pwm_15_8`, `pwm_duty_cycle`  out  8 each  PWM configuration registers.
- `busy`  out  1  high while the sequencer is not IDLE.
- `step_idx`  out  $clog2(DEPTH)  index of the step currently applied.
- `seq_done`  out  1  one-cycle pulse when a one-shot run completes.

## Operation
- Address map:
  - 0x00–0x04: PWM registers in port order.
  - 0x10: SEQ_CTRL; bit0 = run, bit1 = loop.
  - 0x11: SEQ_LEN.
  - 0x12: DWELL, in ticks.
  - 0x20..0x20+DEPTH-1: step table.
  - Writes to any other address are ignored.
- Reset values:
  - All PWM registers, the step table, SEQ_CTRL and all outputs: 0.
  - SEQ_LEN = 1 and DWELL = 1.
- Effective values:
  - Length L = clamp(SEQ_LEN, 1, DEPTH).
  - Dwell D = max(DWELL, 1).
- FSM states: IDLE, LOAD, DWELL.
  - IDLE → LOAD on a write to SEQ_CTRL with bit0 = 1. `step_idx` is set to 0.
  - LOAD (1 cycle): `pwm_duty_cycle` ← table[`step_idx`]. The dwell counter is loaded with D×PRESCALE−1. Next state is DWELL.
  - DWELL: the counter decrements each cycle. At 0:
    - If `step_idx` < L−1: `step_idx`++, → LOAD.
    - Else if loop = 1: `step_idx` ← 0, → LOAD.
    - Else: → IDLE, `seq_done` pulses, SEQ_CTRL bit0 clears.
  - Any state → IDLE on a write to SEQ_CTRL with bit0 = 0. `pwm_duty_cycle` and `step_idx` hold their current values, and `seq_done` does not pulse.
  - A write of SEQ_CTRL bit0 = 1 while running only updates the loop bit; it does not restart the run.
- Writes during a run:
  - SEQ_LEN, DWELL and table writes take effect at the next LOAD or end-of-dwell evaluation.
  - A write to the table entry being loaded in the same cycle delivers the new data to `pwm_duty_cycle`.
- Conflict: a host write to 0x04 in the LOAD cycle wins for that cycle. The sequencer's value is applied at the next LOAD.
- A host write to 0x04 during DWELL is applied immediately and persists until the next LOAD.

## Timing
- Register writes are visible on outputs the cycle after `wr_valid`.
- Start latency:
  - Start strobe in cycle T → LOAD in T+1.
  - table[0] on `pwm_duty_cycle` from T+2.
- Step period is D×PRESCALE+1 cycles (DWELL plus LOAD).
- `seq_done` is high for exactly the one cycle after the final DWELL count reaches 0; `busy` is low in that same cycle.
- Asynchronous reset mid-run forces IDLE and all reset values immediately.

## Configuration
- `PWM_SEQ_LOOP_EN` defined: the loop bit is honored as above.
- Undefined: SEQ_CTRL bit1 is ignored (reads as 0), and every run is one-shot ending with `seq_done`.

## Structure
- Package `pwm_seq_pkg` holds:
  - address constants (REG_* for 0x00–0x04, SEQ_CTRL, SEQ_LEN, SEQ_DWELL, TABLE_BASE);
  - the state enum `seq_state_t` {IDLE, LOAD, DWELL};
  - CTRL bit-position constants.
- One sub-module, `pwm_seq_timer`: prescaler plus dwell down-counter with `load`, `clear` and `expire` signals, parameterized by PRESCALE.

## Test plan
Bench uses PRESCALE = 4.
- Write 0x00 = 0xA5 and 0x04 = 0x80 → the next cycle `en_reg_out_7_0` = 0xA5 and `pwm_duty_cycle` = 0x80; a write to 0x7F changes nothing.
- Table = {0x10, 0x20, 0x30}, LEN = 3, DWELL = 2, start one-shot at T → duty sequence:
  - 0x10 at T+2;
  - 0x20 at T+11;
  - 0x30 at T+20;
  - `seq_done` at T+28 and `busy` low from T+28.
- Same table with loop = 1 → after 0x30, 0x10 reappears at T+29 and `busy` stays high. Writing SEQ_CTRL = 0 stops the run with duty frozen.
- SEQ_LEN = 0 and DWELL = 0 → one step, 4-cycle dwell, then `seq_done`; SEQ_LEN = 20 clamps to 8 steps.
- Host writes 0x04 = 0xFF in the LOAD cycle → 0xFF on duty; the next LOAD overrides it with the table value.
- Assert `rst_n` low mid-DWELL → `busy`, `step_idx` and `pwm_duty_cycle` go to 0 immediately; there is no `seq_done` after release.
